// File: rtl/stream_demux.sv
// Registered 1-to-3 stream demultiplexer with a one-word output register per channel.
// Optional dropped-word counter enabled by defining STREAM_DEMUX_DROP_CNT_EN.
module stream_demux #(
    parameter int unsigned WIDTH = 32,
    parameter int unsigned CNT_W = 8
) (
    input  logic                 clk,
    input  logic                 arst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     in_data,
    input  logic [1:0]           in_sel,
    output logic [2:0]           out_valid,
    input  logic [2:0]           out_ready,
    output logic [3*WIDTH-1:0]   out_data,
    output logic [CNT_W-1:0]     drop_cnt
);

    logic [3:0] blocked;
    logic       accept;
    logic [2:0] wr;

    // Slot 3 is never blocked, so invalid-select words are always accepted.
    always_comb begin
        blocked  = {1'b0, out_valid & ~out_ready};
        in_ready = ~arst & ~blocked[in_sel];
        accept   = in_valid & in_ready;
    end

    genvar n;
    generate
        for (n = 0; n < 3; n++) begin : g_chan
            assign wr[n] = accept && (in_sel == 2'(n));

            always_ff @(posedge clk or posedge arst) begin
                if (arst) begin
                    out_valid[n]                <= 1'b0;
                    out_data[n*WIDTH +: WIDTH]  <= '0;
                end else if (wr[n]) begin
                    out_valid[n]                <= 1'b1;
                    out_data[n*WIDTH +: WIDTH]  <= in_data;
                end else if (out_ready[n]) begin
                    out_valid[n]                <= 1'b0;
                end
            end
        end
    endgenerate

`ifdef STREAM_DEMUX_DROP_CNT_EN
    logic drop;
    assign drop = accept && (in_sel == 2'd3);

    always_ff @(posedge clk or posedge arst) begin
        if (arst) begin
            drop_cnt <= '0;
        end else if (drop && (drop_cnt != '1)) begin
            drop_cnt <= drop_cnt + CNT_W'(1);
        end
    end
`else
    assign drop_cnt = '0;
`endif

endmodule

// File: tb/tb_stream_demux.sv
// Directed self-checking bench for stream_demux; expectations follow the
// STREAM_DEMUX_DROP_CNT_EN setting of the build.
module tb_stream_demux;

    localparam int unsigned WIDTH = 32;
    localparam int unsigned CNT_W = 8;

    logic               clk;
    logic               arst;
    logic               in_valid;
    logic               in_ready;
    logic [WIDTH-1:0]   in_data;
    logic [1:0]         in_sel;
    logic [2:0]         out_valid;
    logic [2:0]         out_ready;
    logic [3*WIDTH-1:0] out_data;
    logic [CNT_W-1:0]   drop_cnt;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    stream_demux #(.WIDTH(WIDTH), .CNT_W(CNT_W)) dut (
        .clk       (clk),
        .arst      (arst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_sel    (in_sel),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .drop_cnt  (drop_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [95:0] act, input logic [95:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fails++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    function automatic logic [WIDTH-1:0] ch(input int unsigned idx);
        return out_data[idx*WIDTH +: WIDTH];
    endfunction

    function automatic logic [CNT_W-1:0] exp_drops(input int unsigned k);
`ifdef STREAM_DEMUX_DROP_CNT_EN
        return (k > 255) ? 8'd255 : CNT_W'(k);
`else
        return k == 0 ? '0 : '0;
`endif
    endfunction

    initial begin
        arst      = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        in_sel    = '0;
        out_ready = '0;
        #3;
        check("rst_in_ready", in_ready, 0);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_data", out_data, 0);
        check("rst_drop_cnt", drop_cnt, 0);
        @(negedge clk);
        arst = 1'b0;
        step();

        // Single route to channel 2
        in_valid = 1'b1; in_data = 32'hDEADBEEF; in_sel = 2'd2;
        #1 check("route_in_ready", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("route_valid", out_valid, 3'b100);
        check("route_data", ch(2), 32'hDEADBEEF);
        step(); step();
        check("route_hold_valid", out_valid, 3'b100);
        out_ready = 3'b100;
        step();
        out_ready = 3'b000;
        check("route_drained", out_valid, 3'b000);
        check("route_data_kept", ch(2), 32'hDEADBEEF);

        // Backpressure on channel 0
        in_valid = 1'b1; in_data = 32'h11111111; in_sel = 2'd0;
        step();
        in_data = 32'h22222222;
        #1 check("bp_in_ready_low", in_ready, 0);
        step();
        check("bp_data_unchanged", ch(0), 32'h11111111);
        check("bp_valid_held", out_valid, 3'b001);
        out_ready = 3'b001;
        #1 check("bp_in_ready_high", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("bp_new_word", ch(0), 32'h22222222);
        check("bp_valid_stays", out_valid, 3'b001);
        step();
        out_ready = 3'b000;
        check("bp_drained", out_valid, 3'b000);

        // Independence: channel 1 stalled while 0 and 2 accept
        in_valid = 1'b1; in_data = 32'hCAFEF00D; in_sel = 2'd1;
        step();
        in_data = 32'h1; in_sel = 2'd0;
        #1 check("ind_ready_ch0", in_ready, 1);
        step();
        check("ind_ch1_mid", ch(1), 32'hCAFEF00D);
        in_data = 32'h2; in_sel = 2'd2;
        #1 check("ind_ready_ch2", in_ready, 1);
        step();
        in_valid = 1'b0;
        check("ind_valid", out_valid, 3'b111);
        check("ind_ch0", ch(0), 32'h1);
        check("ind_ch1", ch(1), 32'hCAFEF00D);
        check("ind_ch2", ch(2), 32'h2);
        out_ready = 3'b101;
        step();
        out_ready = 3'b000;
        check("ind_ch1_still_full", out_valid, 3'b010);

        // Invalid select words are dropped
        in_valid = 1'b1; in_sel = 2'd3;
        for (int i = 0; i < 5; i++) begin
            in_data = 32'hBAD0_0000 + i;
            #1 check("drop_in_ready", in_ready, 1);
            step();
        end
        in_valid = 1'b0;
        check("drop_valid_unchanged", out_valid, 3'b010);
        check("drop_ch1_unchanged", ch(1), 32'hCAFEF00D);
        check("drop_cnt_5", drop_cnt, exp_drops(5));

        // Asynchronous reset mid-stream with channel 1 full
        in_valid = 1'b1; in_sel = 2'd0; in_data = 32'h55555555;
        #2 arst = 1'b1;
        #1;
        check("arst_valid", out_valid, 3'b000);
        check("arst_data", out_data, 0);
        check("arst_drop_cnt", drop_cnt, 0);
        check("arst_in_ready", in_ready, 0);
        @(negedge clk);
        arst = 1'b0;
        in_valid = 1'b0;
        step();

        // Saturation of the drop counter
        in_valid = 1'b1; in_sel = 2'd3;
        for (int i = 0; i < 254; i++) step();
        check("drop_cnt_254", drop_cnt, exp_drops(254));
        for (int i = 0; i < 46; i++) step();
        in_valid = 1'b0;
        check("drop_cnt_sat", drop_cnt, exp_drops(300));

        // Full-rate rotation across all channels
        out_ready = 3'b111;
        for (int i = 0; i < 30; i++) begin
            in_valid = 1'b1;
            in_sel   = 2'(i % 3);
            in_data  = 32'h1000 + i;
            #1 check("tput_in_ready", in_ready, 1);
            step();
            check("tput_valid", out_valid[i % 3], 1);
            check("tput_data", ch(i % 3), 32'h1000 + i);
        end
        in_valid = 1'b0;
        step();
        check("tput_drained", out_valid, 3'b000);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
